// File: rtl/reg_add.sv
// reg_add: adder holding register with optional decimal (BCD) correction.
// Define REG_ADD_DECIMAL_EN to build in the DEC_LO/DEC_HI correction steps.
module reg_add (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_CARRY,
    input  logic       ALU_HALF_CARRY,
    input  logic       ALU_OVF,
    input  logic       ADD_LOAD,
    input  logic       DAA_EN,
    input  logic       SUB,
    input  logic       SB_DRIVE,
    input  logic       ADL_DRIVE,
    output logic [7:0] SB_DATA,
    output logic [7:0] ADL_DATA,
    output logic       SB_OE,
    output logic       ADL_OE,
    output logic       CARRY_OUT,
    output logic       OVF_OUT,
    output logic       BUSY,
    output logic       VALID
);

    localparam int DATA_W = 8;

`ifdef REG_ADD_DECIMAL_EN
    typedef enum logic [1:0] {IDLE, DEC_LO, DEC_HI, HOLD} state_t;
`else
    typedef enum logic [0:0] {IDLE, HOLD} state_t;
`endif

    state_t state_q, state_d;

    logic [DATA_W-1:0] value_p0;
    logic              carry_p0;
    logic              ovf_p0;
    logic              load_ok;

`ifdef REG_ADD_DECIMAL_EN
    logic half_p0;
    logic sub_p0;

    // Low-nibble step; add and subtract use opposite sense of the half-carry.
    function automatic logic [DATA_W-1:0] dec_lo_fix(input logic [DATA_W-1:0] v,
                                                     input logic h, input logic s);
        if (s)
            return h ? v : v - 8'h06;
        if (h || (v[3:0] > 4'd9))
            return v + 8'h06;
        return v;
    endfunction

    // High-nibble step; returns {carry, value}.
    function automatic logic [DATA_W:0] dec_hi_fix(input logic [DATA_W-1:0] v,
                                                   input logic c, input logic s);
        if (s)
            return {c, (c ? v : v - 8'h60)};
        if (c || (v[7:4] > 4'd9))
            return {1'b1, v + 8'h60};
        return {1'b0, v};
    endfunction
`else
    logic unused_inputs;
    assign unused_inputs = ^{DAA_EN, ALU_HALF_CARRY, SUB};
`endif

    assign load_ok = ADD_LOAD && ((state_q == IDLE) || (state_q == HOLD));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HOLD: begin
                if (ADD_LOAD) begin
`ifdef REG_ADD_DECIMAL_EN
                    state_d = DAA_EN ? DEC_LO : HOLD;
`else
                    state_d = HOLD;
`endif
                end
            end
`ifdef REG_ADD_DECIMAL_EN
            DEC_LO:  state_d = DEC_HI;
            DEC_HI:  state_d = HOLD;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Capture stage: loads take priority; correction steps rewrite the held value in place.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value_p0 <= '0;
            carry_p0 <= 1'b0;
            ovf_p0   <= 1'b0;
`ifdef REG_ADD_DECIMAL_EN
            half_p0  <= 1'b0;
            sub_p0   <= 1'b0;
`endif
        end else if (load_ok) begin
            value_p0 <= ALU_RESULT;
            carry_p0 <= ALU_CARRY;
            ovf_p0   <= ALU_OVF;
`ifdef REG_ADD_DECIMAL_EN
            half_p0  <= ALU_HALF_CARRY;
            sub_p0   <= SUB;
`endif
        end
`ifdef REG_ADD_DECIMAL_EN
        else if (state_q == DEC_LO) begin
            value_p0 <= dec_lo_fix(value_p0, half_p0, sub_p0);
        end else if (state_q == DEC_HI) begin
            {carry_p0, value_p0} <= dec_hi_fix(value_p0, carry_p0, sub_p0);
        end
`endif
    end

    assign VALID = (state_q == HOLD);
`ifdef REG_ADD_DECIMAL_EN
    assign BUSY  = (state_q == DEC_LO) || (state_q == DEC_HI);
`else
    assign BUSY  = 1'b0;
`endif

    assign CARRY_OUT = carry_p0;
    assign OVF_OUT   = ovf_p0;

    assign SB_OE    = SB_DRIVE && VALID;
    assign ADL_OE   = ADL_DRIVE && VALID;
    assign SB_DATA  = SB_OE  ? value_p0 : 8'h00;
    assign ADL_DATA = ADL_OE ? value_p0 : 8'h00;

endmodule

// File: doc/reg_add.md
REG_ADD -- requirements
Module: reg_ADD

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port ALU_RESULT, input, 8 bits: raw adder sum or difference from the ALU.
REQ-004 SHALL have ports ALU_CARRY, ALU_HALF_CARRY and ALU_OVF, input, 1 bit each: carry from bit 7, carry from bit 3, and signed overflow from the ALU.
REQ-005 SHALL have port ADD_LOAD, input, 1 bit: capture the ALU outputs this cycle.
REQ-006 SHALL have port DAA_EN, input, 1 bit: apply decimal (BCD) correction to the captured value.
REQ-007 SHALL have port SUB, input, 1 bit: the captured operation was a subtraction; selects the decimal rule.
REQ-008 SHALL have ports SB_DRIVE and ADL_DRIVE, input, 1 bit each: requests to drive the SB bus and the ADL bus.
REQ-009 SHALL have ports SB_DATA and ADL_DATA, output, 8 bits each: bus data; 8'h00 when not driving.
REQ-010 SHALL have ports SB_OE and ADL_OE, output, 1 bit each: the matching bus is being driven.
REQ-011 SHALL have ports CARRY_OUT and OVF_OUT, output, 1 bit each: final carry and overflow flags.
REQ-012 SHALL have ports BUSY and VALID, output, 1 bit each: correction in progress, and the held value is final.

Function
REQ-013 SHALL implement four states: IDLE, DEC_LO, DEC_HI and HOLD.
REQ-014 ADD_LOAD while in IDLE or HOLD SHALL capture ALU_RESULT, ALU_CARRY, ALU_HALF_CARRY, ALU_OVF and SUB at the rising edge.
REQ-015 After that capture, if DAA_EN=0, SHALL go to HOLD; VALID=1 the following cycle, for a latency of 1.
REQ-016 After that capture, if DAA_EN=1, SHALL go to DEC_LO with BUSY=1 and VALID=0.
REQ-017 DEC_LO, add (SUB=0): if the captured half-carry is 1 or the low nibble is greater than 9, SHALL add 8'h06, modulo 256; then go to DEC_HI.
REQ-018 DEC_LO, subtract (SUB=1): if the captured half-carry is 0, SHALL subtract 8'h06, modulo 256; then go to DEC_HI.
REQ-019 DEC_HI, add: if the captured carry is 1 or the high nibble is greater than 9 (after the DEC_LO step), SHALL add 8'h60 modulo 256 and set CARRY_OUT=1; otherwise CARRY_OUT keeps the captured carry.
REQ-020 DEC_HI, subtract: if the captured carry is 0, SHALL subtract 8'h60 modulo 256; CARRY_OUT keeps the captured carry.
REQ-021 DEC_HI SHALL always go to HOLD; decimal latency is 3 cycles from ADD_LOAD to VALID=1.
REQ-022 OVF_OUT SHALL equal the captured ALU_OVF; decimal correction never alters it.
REQ-023 ADD_LOAD while BUSY=1 SHALL be ignored; the correction completes unchanged.
REQ-024 ADD_LOAD in HOLD SHALL overwrite the held value and drop VALID until the new result is final.
REQ-025 SB_OE SHALL equal SB_DRIVE AND VALID; SB_DATA SHALL equal the held value when SB_OE=1, else 8'h00.
REQ-026 ADL_OE and ADL_DATA SHALL follow the same rule using ADL_DRIVE.
REQ-027 Both buses MAY be driven at the same time; the outputs are combinational from state and inputs.
REQ-028 The held value SHALL persist in HOLD indefinitely until the next ADD_LOAD or RST.

Reset
REQ-029 RST=1 SHALL immediately force state IDLE, held value 8'h00, CARRY_OUT=0, OVF_OUT=0, BUSY=0, VALID=0, SB_OE=0, ADL_OE=0, SB_DATA=8'h00 and ADL_DATA=8'h00.
REQ-030 RST asserted in DEC_LO or DEC_HI SHALL abort the correction with no partial result visible.
REQ-031 After RST deasserts, the first ADD_LOAD SHALL be accepted at the next rising edge.

Configuration
REQ-032 Macro REG_ADD_DECIMAL_EN defined: decimal correction SHALL be present as specified above.
REQ-033 Macro REG_ADD_DECIMAL_EN undefined: DAA_EN SHALL be ignored, DEC_LO and DEC_HI SHALL not exist, every load SHALL complete with latency 1, BUSY SHALL be constant 0, and CARRY_OUT SHALL equal the captured ALU_CARRY.

Verification
REQ-034 Load ALU_RESULT=8'hBB with DAA_EN=0, then SB_DRIVE=1 and ADL_DRIVE=0 -> VALID=1 after 1 cycle, SB_DATA=8'hBB, SB_OE=1, ADL_DATA=8'h00.
REQ-035 Decimal add, BCD 15+27: ALU_RESULT=8'h3C, H=0, C=0, DAA_EN=1 -> BUSY for 2 cycles, then SB_DATA=8'h42, CARRY_OUT=0.
REQ-036 Decimal add, BCD 99+01: ALU_RESULT=8'h9A, H=0, C=0, DAA_EN=1 -> held value 8'h00, CARRY_OUT=1.
REQ-037 Decimal subtract, BCD 10-01: ALU_RESULT=8'h0F, H=0, C=1, SUB=1, DAA_EN=1 -> held value 8'h09, CARRY_OUT=1.
REQ-038 ADD_LOAD of 8'h55 during DEC_LO of REQ-035 -> ignored, result still 8'h42; then RST pulsed during DEC_HI of a new decimal load -> all outputs zero, VALID=0.
REQ-039 Both drives asserted in HOLD with held value 8'h7E -> SB_DATA=ADL_DATA=8'h7E; both drives deasserted -> both buses 8'h00, both OE=0.
